verilator_uart_rx_multi: RTL and testbench

Parametrised multi-channel UART receive monitor for Verilator testbenches. It decodes one or more DUT UART TX lines into bytes for the C++ harness. Each channel has:
- configurable data width, parity and stop bits
- start-bit glitch rejection
- per-character frame, parity and break status

It sits in the simulation wrapper between the SoC's `uart_tx_o` pin(s) and the harness byte interface.

---
 rtl/verilator_uart_pkg.sv | 29 ++
 rtl/verilator_uart_rx_chan.sv | 155 +++++++++++++++
 rtl/verilator_uart_rx_multi.sv | 75 +++++++
 tb/tb_verilator_uart_rx_multi.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/verilator_uart_pkg.sv
// Shared types and defaults for the multi-channel UART receive monitor.
package verilator_uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE,
      PARITY_EVEN,
      PARITY_ODD
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   // 115200 baud at a 5 ns clock.
   localparam int unsigned DefaultBaudPeriodCycles = 1736;

   // One received character with its status.
   typedef struct packed {
      logic [7:0] data;
      logic       frame_err;
      logic       parity_err;
      logic       brk;
   } rx_char_t;

endpackage

// File: rtl/verilator_uart_rx_chan.sv
// One UART receive channel: 2-FF synchroniser, start-glitch filter,
// bit-timing counter, LSB-first shift register and status generation.
module verilator_uart_rx_chan
   import verilator_uart_pkg::*;
#(
   parameter int unsigned BaudPeriodCycles = DefaultBaudPeriodCycles,
   parameter int unsigned DataBits         = 8,
   parameter parity_e     ParityMode       = PARITY_NONE,
   parameter int unsigned StopBits         = 1
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     rx_i,
   output logic     valid_o,
   output rx_char_t char_o
);

   localparam int unsigned CntW      = $clog2(BaudPeriodCycles);
   localparam int unsigned BitCntW   = 3;
   localparam logic [CntW-1:0]    HalfLast  = CntW'(BaudPeriodCycles / 2 - 1);
   localparam logic [CntW-1:0]    BitLast   = CntW'(BaudPeriodCycles - 1);
   localparam logic [BitCntW-1:0] DataLast  = BitCntW'(DataBits - 1);
   localparam logic [BitCntW-1:0] StopLast  = BitCntW'(StopBits - 1);

   logic [1:0]         sync_q, sync_d;
   logic [1:0]         flushed_q, flushed_d;
   logic               prev_q, prev_d;
   rx_state_e          state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]         shift_q, shift_d;
   logic               par_q, par_d;
   logic               fe_q, fe_d;
   logic               valid_q, valid_d;
   rx_char_t           char_q, char_d;

   logic       line;
   logic       bit_tick;
   logic       fe_now;
   logic       par_err;
   logic [7:0] data_now;

   assign line     = sync_q[1];
   assign bit_tick = (cnt_q == BitLast);
   assign fe_now   = fe_q | ~line;
   assign data_now = shift_q >> (8 - DataBits);

   always_comb begin
      par_err = 1'b0;
      if (ParityMode == PARITY_EVEN) par_err = par_q;
      if (ParityMode == PARITY_ODD)  par_err = ~par_q;
   end

   // Next-state logic; edges only count once the synchroniser holds real line samples.
   always_comb begin
      sync_d    = {sync_q[0], rx_i};
      flushed_d = {flushed_q[0], 1'b1};
      prev_d    = flushed_q[1] & line;
      state_d   = state_q;
      cnt_d     = cnt_q + CntW'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      fe_d      = fe_q;
      valid_d   = 1'b0;
      char_d    = char_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (prev_q && !line) begin
               state_d   = START;
               bit_cnt_d = '0;
               par_d     = 1'b0;
               fe_d      = 1'b0;
            end
         end
         START: begin
            if (cnt_q == HalfLast) begin
               cnt_d   = '0;
               state_d = line ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_d   = '0;
               shift_d = {line, shift_q[7:1]};
               par_d   = par_q ^ line;
               if (bit_cnt_q == DataLast) begin
                  bit_cnt_d = '0;
                  state_d   = (ParityMode == PARITY_NONE) ? STOP : PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + BitCntW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               cnt_d   = '0;
               par_d   = par_q ^ line;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               cnt_d = '0;
               fe_d  = fe_now;
               if (bit_cnt_q == StopLast) begin
                  state_d           = IDLE;
                  valid_d           = 1'b1;
                  char_d.data       = data_now;
                  char_d.frame_err  = fe_now;
                  char_d.parity_err = par_err;
                  char_d.brk        = fe_now & (data_now == 8'h00);
               end else begin
                  bit_cnt_d = bit_cnt_q + BitCntW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q    <= 2'b11;
         flushed_q <= 2'b00;
         prev_q    <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         fe_q      <= 1'b0;
         valid_q   <= 1'b0;
         char_q    <= '0;
      end else begin
         sync_q    <= sync_d;
         flushed_q <= flushed_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         fe_q      <= fe_d;
         valid_q   <= valid_d;
         char_q    <= char_d;
      end
   end

   assign valid_o = valid_q;
   assign char_o  = char_q;

endmodule

// File: rtl/verilator_uart_rx_multi.sv
// Multi-channel UART receive monitor for simulation wrappers.
// Set PrintEn to echo characters and error warnings to stdout.
module verilator_uart_rx_multi
   import verilator_uart_pkg::*;
#(
   parameter int unsigned NumChannels      = 1,
   parameter int unsigned BaudPeriodCycles = DefaultBaudPeriodCycles,
   parameter int unsigned DataBits         = 8,
   parameter parity_e     ParityMode       = PARITY_NONE,
   parameter int unsigned StopBits         = 1,
   parameter bit          PrintEn          = 1'b0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumChannels-1:0]      uart_rx_i,
   output logic [NumChannels-1:0]      data_valid_o,
   output logic [NumChannels-1:0][7:0] data_o,
   output logic [NumChannels-1:0]      frame_err_o,
   output logic [NumChannels-1:0]      parity_err_o,
   output logic [NumChannels-1:0]      break_o
);

   if (NumChannels < 1) begin : g_bad_chan
      $fatal(1, "NumChannels must be at least 1");
   end
   if (BaudPeriodCycles < 4) begin : g_bad_baud
      $fatal(1, "BaudPeriodCycles must be at least 4");
   end
   if (DataBits < 5 || DataBits > 8) begin : g_bad_data
      $fatal(1, "DataBits must be within 5..8");
   end
   if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
      $fatal(1, "StopBits must be 1 or 2");
   end

   for (genvar g = 0; g < NumChannels; g++) begin : g_chan
      rx_char_t chr;

      verilator_uart_rx_chan #(
         .BaudPeriodCycles (BaudPeriodCycles),
         .DataBits         (DataBits),
         .ParityMode       (ParityMode),
         .StopBits         (StopBits)
      ) u_chan (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .rx_i    (uart_rx_i[g]),
         .valid_o (data_valid_o[g]),
         .char_o  (chr)
      );

      assign data_o[g]       = chr.data;
      assign frame_err_o[g]  = chr.frame_err;
      assign parity_err_o[g] = chr.parity_err;
      assign break_o[g]      = chr.brk;

      if (PrintEn) begin : g_print
         // Channel prefix is printed only at the start of each output line.
         logic line_start_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               line_start_q <= 1'b1;
            end else if (data_valid_o[g]) begin
               if (NumChannels > 1 && line_start_q) $write("[ch%0d] ", g);
               $write("%c", data_o[g]);
               line_start_q <= (data_o[g] == 8'h0a);
               if (break_o[g])           $display("\nuart_rx ch%0d warning: break", g);
               else if (frame_err_o[g])  $display("\nuart_rx ch%0d warning: framing error", g);
               if (parity_err_o[g])      $display("\nuart_rx ch%0d warning: parity error", g);
            end
         end
      end
   end

endmodule

// File: tb/tb_verilator_uart_rx_multi.sv
// Scoreboard bench: stimulus pushes expected characters, a negedge monitor pops and compares.
module tb_verilator_uart_rx_multi;
   import verilator_uart_pkg::*;

   localparam int unsigned P = 16;
   localparam int unsigned H = P / 2;

   typedef struct {
      int          ln;
      logic [7:0]  data;
      logic        fe;
      logic        pe;
      logic        brk;
      int unsigned cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  line  = 4'hf;
   int unsigned cyc   = 0;
   int          n_vec = 0;
   int          n_mis = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line 0: 8N1, line 1: 7E1, lines 2/3: two-channel 8N2.
   logic       va, fea, pea, ba;
   logic [7:0] da;
   logic       vb, feb, peb, bb;
   logic [7:0] db;
   logic [1:0] vc, fec, pec, bc;
   logic [1:0][7:0] dc;

   verilator_uart_rx_multi #(.NumChannels(1), .BaudPeriodCycles(P), .DataBits(8),
                             .ParityMode(PARITY_NONE), .StopBits(1)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(line[0]), .data_valid_o(va), .data_o(da),
      .frame_err_o(fea), .parity_err_o(pea), .break_o(ba));

   verilator_uart_rx_multi #(.NumChannels(1), .BaudPeriodCycles(P), .DataBits(7),
                             .ParityMode(PARITY_EVEN), .StopBits(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(line[1]), .data_valid_o(vb), .data_o(db),
      .frame_err_o(feb), .parity_err_o(peb), .break_o(bb));

   verilator_uart_rx_multi #(.NumChannels(2), .BaudPeriodCycles(P), .DataBits(8),
                             .ParityMode(PARITY_NONE), .StopBits(2)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(line[3:2]), .data_valid_o(vc), .data_o(dc),
      .frame_err_o(fec), .parity_err_o(pec), .break_o(bc));

   logic [3:0] m_v, m_fe, m_pe, m_brk;
   logic [7:0] m_d [4];
   assign m_v   = {vc, vb, va};
   assign m_fe  = {fec, feb, fea};
   assign m_pe  = {pec, peb, pea};
   assign m_brk = {bc, bb, ba};
   assign m_d[0] = da;
   assign m_d[1] = db;
   assign m_d[2] = dc[0];
   assign m_d[3] = dc[1];

   function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one frame and records the character the DUT should deliver.
   task automatic send_char(input int ln, input logic [7:0] d, input int nd, input int has_par,
                            input logic pbit, input int nstop, input logic stop_v,
                            input logic [7:0] ed, input logic efe, input logic epe,
                            input logic ebrk);
      exp_t e;
      e.ln   = ln;
      e.data = ed;
      e.fe   = efe;
      e.pe   = epe;
      e.brk  = ebrk;
      e.cyc  = cyc + 2 + H + (nd + has_par + nstop) * P + 1;
      sb.push_back(e);
      line[ln] = 1'b0;
      tick(P);
      for (int i = 0; i < nd; i++) begin
         line[ln] = d[i];
         tick(P);
      end
      if (has_par != 0) begin
         line[ln] = pbit;
         tick(P);
      end
      for (int i = 0; i < nstop; i++) begin
         line[ln] = stop_v;
         tick(P);
      end
      line[ln] = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int ln = 0; ln < 4; ln++) begin
            if (m_v[ln]) begin
               int   idx;
               exp_t e;
               idx = -1;
               foreach (sb[i]) if (idx < 0 && sb[i].ln == ln) idx = i;
               if (idx < 0) begin
                  n_vec++;
                  n_mis++;
                  $display("FAIL unexpected_valid line%0d: got valid with data %02h, required no valid",
                           ln, m_d[ln]);
               end else begin
                  e = sb[idx];
                  sb.delete(idx);
                  chk($sformatf("valid_cycle line%0d", ln), cyc, e.cyc);
                  chk($sformatf("data line%0d", ln), 32'(m_d[ln]), 32'(e.data));
                  chk($sformatf("frame_err line%0d", ln), 32'(m_fe[ln]), 32'(e.fe));
                  chk($sformatf("parity_err line%0d", ln), 32'(m_pe[ln]), 32'(e.pe));
                  chk($sformatf("break line%0d", ln), 32'(m_brk[ln]), 32'(e.brk));
               end
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, " valid"},  32'({vc, vb, va}), 0);
      chk({tag, " data_a"}, 32'(da), 0);
      chk({tag, " data_b"}, 32'(db), 0);
      chk({tag, " data_c"}, 32'(dc), 0);
      chk({tag, " flags"},  32'({fec, pec, bc, feb, peb, bb, fea, pea, ba}), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick(3);
      chk_all_zero("reset_state");
      rst_n = 1'b1;
      tick(4);
      chk_all_zero("post_reset");

      // 8N1 basic character.
      send_char(0, 8'h41, 8, 0, 1'b0, 1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
      tick(P);

      // 7E1: correct parity, then wrong parity.
      send_char(1, 8'h55, 7, 1, 1'b0, 1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      tick(P);
      send_char(1, 8'h55, 7, 1, 1'b1, 1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      tick(P);

      // Break: zero data, zero stop, line kept low; held-low line must not retrigger.
      send_char(0, 8'h00, 8, 0, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      line[0] = 1'b0;
      tick(40 * P);
      line[0] = 1'b1;
      tick(P);
      send_char(0, 8'h5A, 8, 0, 1'b0, 1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      tick(P);

      // Short low glitch is rejected, next frame decodes cleanly.
      line[0] = 1'b0;
      tick(5);
      line[0] = 1'b1;
      tick(3 * P);
      send_char(0, 8'hA5, 8, 0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      tick(P);

      // Two channels with identical start edges complete together.
      fork
         send_char(2, 8'h12, 8, 0, 1'b0, 2, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
         send_char(3, 8'h34, 8, 0, 1'b0, 2, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
      join
      tick(P);

      // Reset mid-frame after four data bits of 0x3C; line 1 stays low across release.
      line[0] = 1'b0;
      tick(P);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] pat;
         pat = 8'h3C;
         line[0] = pat[i];
         tick(P);
      end
      line[1] = 1'b0;
      rst_n   = 1'b0;
      tick(2);
      chk_all_zero("mid_reset");
      line[0] = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(3 * P);
      line[1] = 1'b1;
      tick(5);
      send_char(0, 8'h7E, 8, 0, 1'b0, 1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
      send_char(1, 8'h2A, 7, 1, 1'b1, 1, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);

      tick(4 * P);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         n_mis++;
         $display("FAIL missing_valid line%0d: got no valid, required data %02h at cycle %0d",
                  e.ln, e.data, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
